// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit.
//   ALU_*          : alu_ctr encodings (bit 3 is a don't-care for sll, pass-B, xor, or, and;
//                    those are listed with bit 3 cleared and the top normalises before decode)
//   MD_*           : md_funct3 encodings for the RV32M group
//   md_state_e     : sequencing FSM states
//   ALU_DATA_WIDTH : default operand width
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} md_state_e;

endpackage

// File: rtl/alu_md_unit_if.sv
// Request/response bundle of the ALU / multiply-divide unit.
//   master : issuer side (drives request and out_ready)
//   slave  : unit side (drives in_ready and the registered result)
interface alu_md_unit_if #(
  parameter int unsigned DATA_WIDTH = alu_pkg::ALU_DATA_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [3:0]            alu_ctr;
  logic                  md_en;
  logic [2:0]            md_funct3;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  less;

  modport master (
    output in_valid, a, b, alu_ctr, md_en, md_funct3, out_ready,
    input  in_ready, out_valid, result, zero, less
  );

  modport slave (
    input  in_valid, a, b, alu_ctr, md_en, md_funct3, out_ready,
    output in_ready, out_valid, result, zero, less
  );
endinterface

// File: rtl/md_iter.sv
// Iterative radix-2 multiply / restoring divide datapath.
//   start   : request accepted this cycle; operands on a/b/funct3 are consumed
//   special : divide resolves without iterating (divisor 0 or signed overflow)
//   done    : the final iteration happens on the coming edge
//   result  : sign-fixed, word-selected result, stable once iteration has finished
// The first step is applied on the accepting edge itself, so DATA_WIDTH steps
// complete DATA_WIDTH-1 edges after start.
module md_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  special,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  logic [2*W-1:0]   acc_q, acc_src, step_next, mul_next, div_next, prod;
  logic [W-1:0]     opnd_q, opnd_src, a_mag, b_mag, special_val, special_val_q;
  logic [W-1:0]     quo, rem;
  logic [W:0]       sum, rem_sh, diff;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             div_q, div_src, neg_q, rem_neg_q, special_q, running_q;
  logic             a_signed, b_signed, a_neg, b_neg, overflow;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (funct3)
      MD_MULH, MD_DIV, MD_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      MD_MULHSU:               a_signed = 1'b1;
      MD_MUL, MD_MULHU, MD_DIVU, MD_REMU: ;
      default: ;
    endcase
  end

  assign a_neg    = a_signed & a[W-1];
  assign b_neg    = b_signed & b[W-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign overflow = a_signed & (a == {1'b1, {(W-1){1'b0}}}) & (&b);
  assign special  = funct3[2] & ((b == '0) | overflow);

  // funct3[1] distinguishes rem/remu from div/divu
  always_comb begin
    if (b == '0) special_val = funct3[1] ? a : '1;
    else         special_val = funct3[1] ? '0 : a;
  end

  // Both mul and div start from {0, |a|} with |b| as multiplicand / divisor.
  assign acc_src  = start ? {{W{1'b0}}, a_mag} : acc_q;
  assign opnd_src = start ? b_mag : opnd_q;
  assign div_src  = start ? funct3[2] : div_q;

  assign sum      = {1'b0, acc_src[2*W-1:W]} + {1'b0, opnd_src};
  assign mul_next = acc_src[0] ? {sum, acc_src[W-1:1]} : {1'b0, acc_src[2*W-1:1]};

  // Shift in the next dividend bit; keep the difference only if it did not borrow.
  assign rem_sh   = acc_src[2*W-1:W-1];
  assign diff     = rem_sh - {1'b0, opnd_src};
  assign div_next = diff[W] ? {rem_sh[W-1:0], acc_src[W-2:0], 1'b0}
                            : {diff[W-1:0], acc_src[W-2:0], 1'b1};

  assign step_next = div_src ? div_next : mul_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; opnd_q <= '0; cnt_q <= '0; op_q <= '0; div_q <= 1'b0;
      neg_q <= 1'b0; rem_neg_q <= 1'b0; special_q <= 1'b0; special_val_q <= '0;
      running_q <= 1'b0;
    end else if (flush) begin
      acc_q <= '0; opnd_q <= '0; cnt_q <= '0; op_q <= '0; div_q <= 1'b0;
      neg_q <= 1'b0; rem_neg_q <= 1'b0; special_q <= 1'b0; special_val_q <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      acc_q         <= step_next;
      opnd_q        <= b_mag;
      cnt_q         <= CNT_W'(1);
      op_q          <= funct3;
      div_q         <= funct3[2];
      neg_q         <= a_neg ^ b_neg;
      rem_neg_q     <= a_neg;
      special_q     <= special;
      special_val_q <= special_val;
      running_q     <= !special;
    end else if (running_q) begin
      acc_q <= step_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) running_q <= 1'b0;
    end
  end

  assign done = running_q && (cnt_q == CNT_W'(W - 1));

  assign quo = acc_q[W-1:0];
  assign rem = acc_q[2*W-1:W];

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    if (special_q)                 result = special_val_q;
    else if (div_q && op_q[1])     result = rem_neg_q ? -rem : rem;
    else if (div_q)                result = neg_q ? -quo : quo;
    else if (op_q == MD_MUL)       result = prod[W-1:0];
    else                           result = prod[2*W-1:W];
  end

endmodule

// File: rtl/alu_md_unit.sv
// RV32I base ALU plus iterative RV32M multiply/divide behind a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop any in-flight op and clear the output register
//   bus        : request (in_valid/in_ready, a, b, alu_ctr, md_en, md_funct3) and
//                registered response (out_valid/out_ready, result, zero, less)
// Base ops complete in one cycle; mul/div occupy the unit until their result is taken.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_md_unit_if.slave bus
);
  md_state_e             state_q;
  logic                  out_valid_q, zero_q, less_q;
  logic [DATA_WIDTH-1:0] result_q, base_res, md_result;
  logic                  accept, md_start, md_special, md_done, base_less;
  logic [3:0]            ctr;
  logic [SHAMT_W-1:0]    shamt;

  assign bus.in_ready  = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.less      = less_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign md_start = accept && bus.md_en;
  assign shamt    = bus.b[SHAMT_W-1:0];

  // Bit 3 only matters for add/sub, slt/sltu and srl/sra.
  assign ctr = {bus.alu_ctr[3] & (bus.alu_ctr[2:0] inside {3'b000, 3'b010, 3'b101}),
                bus.alu_ctr[2:0]};

  always_comb begin
    base_res  = '0;
    base_less = 1'b0;
    unique case (ctr)
      ALU_ADD:   base_res = bus.a + bus.b;
      ALU_SUB:   base_res = bus.a - bus.b;
      ALU_SLL:   base_res = bus.a << shamt;
      ALU_SLT:   begin
        base_less = $signed(bus.a) < $signed(bus.b);
        base_res  = {{(DATA_WIDTH-1){1'b0}}, base_less};
      end
      ALU_SLTU:  begin
        base_less = bus.a < bus.b;
        base_res  = {{(DATA_WIDTH-1){1'b0}}, base_less};
      end
      ALU_PASSB: base_res = bus.b;
      ALU_XOR:   base_res = bus.a ^ bus.b;
      ALU_SRL:   base_res = bus.a >> shamt;
      ALU_SRA:   base_res = $unsigned($signed(bus.a) >>> shamt);
      ALU_OR:    base_res = bus.a | bus.b;
      ALU_AND:   base_res = bus.a & bus.b;
      default:   ;
    endcase
  end

  md_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_md_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .start   (md_start),
    .funct3  (bus.md_funct3),
    .a       (bus.a),
    .b       (bus.b),
    .special (md_special),
    .done    (md_done),
    .result  (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      less_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      less_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && bus.md_en) begin
            out_valid_q <= 1'b0;
            if (md_special)            state_q <= StDone;
            else if (bus.md_funct3[2]) state_q <= StDiv;
            else                       state_q <= StMul;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= base_res;
            zero_q      <= (bus.a == bus.b);
            less_q      <= base_less;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        StMul, StDiv: begin
          if (md_done) state_q <= StDone;
        end
        StDone: begin
          out_valid_q <= 1'b1;
          result_q    <= md_result;
          zero_q      <= 1'b0;
          less_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
module tb_alu_md_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_md_unit_if #(.DATA_WIDTH(32)) bus ();

  alu_md_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        less;
    logic        zero;
  } base_vec_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } md_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic [2:0] f3, input logic [3:0] ctr,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.in_valid  = 1'b1;
    bus.md_en     = md;
    bus.md_funct3 = f3;
    bus.alu_ctr   = ctr;
    bus.a         = av;
    bus.b         = bv;
  endtask

  task automatic issue(input logic md, input logic [2:0] f3, input logic [3:0] ctr,
                       input logic [31:0] av, input logic [31:0] bv);
    drive(md, f3, ctr, av, bv);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from acceptance until out_valid, and how often in_ready was seen high meanwhile.
  task automatic wait_out(output int lat, output int rdy);
    lat = 1;
    rdy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", bus.result); end
    checks++; if ({bus.zero, bus.less} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b want 00", {bus.zero, bus.less}); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_base();
    base_vec_t v [11];
    v = '{
      '{4'b0000, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0004, 1'b0, 1'b0},
      '{4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1},
      '{4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0},
      '{4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0},
      '{4'b1001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0},
      '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0},
      '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0},
      '{4'b1011, 32'h0000_1234, 32'h0000_5678, 32'h0000_5678, 1'b0, 1'b0},
      '{4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0},
      '{4'b1110, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 1'b0},
      '{4'b0111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0}
    };
    bus.out_ready = 1'b1;
    // Issued one per cycle: each must be accepted and appear the cycle after.
    foreach (v[i]) begin
      issue(1'b0, 3'b000, v[i].ctr, v[i].a, v[i].b);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL base_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.result !== v[i].res) begin failures++; $display("FAIL base_result[%0d]: got %h want %h", i, bus.result, v[i].res); end
      checks++; if (bus.less !== v[i].less) begin failures++; $display("FAIL base_less[%0d]: got %b want %b", i, bus.less, v[i].less); end
      checks++; if (bus.zero !== v[i].zero) begin failures++; $display("FAIL base_zero[%0d]: got %b want %b", i, bus.zero, v[i].zero); end
    end
  endtask

  task automatic test_mul();
    md_vec_t v [6];
    int lat, rdy;
    v = '{
      '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{MD_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE},
      '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{MD_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF}
    };
    foreach (v[i]) begin
      issue(1'b1, v[i].f3, 4'b0000, v[i].a, v[i].b);
      wait_out(lat, rdy);
      checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (bus.result !== v[i].res) begin failures++; $display("FAIL mul_result[%0d]: got %h want %h", i, bus.result, v[i].res); end
      checks++; if (rdy != 0) begin failures++; $display("FAIL mul_in_ready[%0d]: got %0d high cycles want 0", i, rdy); end
      checks++; if ({bus.zero, bus.less} !== 2'b00) begin failures++; $display("FAIL mul_flags[%0d]: got %b want 00", i, {bus.zero, bus.less}); end
    end
  endtask

  task automatic test_div();
    md_vec_t v [7];
    int lat, rdy;
    v = '{
      '{MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{MD_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555},
      '{MD_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
      '{MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
      '{MD_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001},
      '{MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };
    foreach (v[i]) begin
      issue(1'b1, v[i].f3, 4'b0000, v[i].a, v[i].b);
      wait_out(lat, rdy);
      checks++; if (lat != 33) begin failures++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
      checks++; if (bus.result !== v[i].res) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, bus.result, v[i].res); end
      checks++; if (rdy != 0) begin failures++; $display("FAIL div_in_ready[%0d]: got %0d high cycles want 0", i, rdy); end
    end
  endtask

  task automatic test_div_special();
    md_vec_t v [6];
    int lat, rdy;
    v = '{
      '{MD_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
      '{MD_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
      '{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{MD_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
      '{MD_REM,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB}
    };
    foreach (v[i]) begin
      issue(1'b1, v[i].f3, 4'b0000, v[i].a, v[i].b);
      wait_out(lat, rdy);
      checks++; if (lat != 2) begin failures++; $display("FAIL divsp_latency[%0d]: got %0d want 2", i, lat); end
      checks++; if (bus.result !== v[i].res) begin failures++; $display("FAIL divsp_result[%0d]: got %h want %h", i, bus.result, v[i].res); end
    end
  endtask

  task automatic test_backpressure();
    tick();
    bus.out_ready = 1'b0;
    issue(1'b0, 3'b000, ALU_ADD, 32'd10, 32'd20);
    drive(1'b0, 3'b000, ALU_SUB, 32'd100, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.result !== 32'd30 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d]: got %h/%b want 0000001e/1", i, bus.result, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.result !== 32'd99 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_next: got %h/%b want 00000063/1", bus.result, bus.out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    bus.out_ready = 1'b1;
    issue(1'b1, MD_DIV, 4'b0000, 32'd1000, 32'd7);
    for (int i = 0; i < 8; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_state: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL flush_result: got %h want 0", bus.result); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    // Flush wins over an acceptance in the same cycle.
    drive(1'b0, 3'b000, ALU_ADD, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept: got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept_late: got %b want 0", bus.out_valid); end
    issue(1'b0, 3'b000, ALU_ADD, 32'd2, 32'd3);
    checks++; if (bus.result !== 32'd5 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_add: got %h/%b want 00000005/1", bus.result, bus.out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    issue(1'b1, MD_MULHU, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_state: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL rst_mid_result: got %h want 0", bus.result); end
    #2;
    rst_n = 1'b1;
    issue(1'b0, 3'b000, ALU_ADD, 32'd4, 32'd5);
    checks++; if (bus.result !== 32'd9 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_add: got %h/%b want 00000009/1", bus.result, bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drain: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.md_en     = 1'b0;
    bus.md_funct3 = 3'b000;
    bus.alu_ctr   = 4'b0000;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b1;
    test_reset();
    test_base();
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised, multi-cycle successor to the single-cycle RV32I ALU. Executes all base ALU operations (same 4-bit control encoding) in one registered cycle and adds the RV32M multiply/divide group with an iterative radix-2 datapath. It sits in the EX stage of the pipelined core behind a valid/ready handshake, so the pipeline stalls on in_ready while a mul/div is in flight.

## Interface
- DATA_WIDTH, 32: operand/result width; power of two, ≥ 8.
- SHAMT_W, $clog2(DATA_WIDTH): shift-amount bits taken from B.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  abandon the current op and clear the output register.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts a request this cycle.
- a, b  in  DATA_WIDTH each  operands.
- alu_ctr  in  4  base op: 0000 add, 1000 sub, z001 sll, 0010 slt, 1010 sltu, z011 pass B, z100 xor, z110 or, z111 and, 0101 srl, 1101 sra, others → 0.
- md_en  in  1  1 selects the M-extension op in md_funct3 and ignores alu_ctr.
- md_funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes the result.
- result  out  DATA_WIDTH  operation result.
- zero  out  1  (a == b) of the accepted request; base ops only, 0 for md ops.
- less  out  1  signed or unsigned compare bit for slt/sltu, else 0.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE. Reset and flush both force IDLE, out_valid=0, result=0, zero=0, less=0, and clear the iteration counter.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A request is accepted when in_valid && in_ready.
- Base op accepted: the result, zero and less are computed combinationally and registered. The FSM stays in IDLE and out_valid is set.
- Shift ops use only b[SHAMT_W-1:0]. sra is arithmetic. slt/sltu place the compare bit in result[0] with the upper bits zeroed.
- Mul accepted: the operands are latched as magnitudes and the result sign is recorded. Sign rules: mulh treats both operands as signed, mulhsu treats a as signed and b as unsigned, mulhu and mul treat both as unsigned magnitudes. Each cycle of MUL runs one shift-add step on a 2·DATA_WIDTH accumulator. After DATA_WIDTH steps the FSM goes to DONE. DONE negates the product if required, selects the low word (mul) or high word (mulh*), sets out_valid, and returns to IDLE.
- Div accepted, special cases: these resolve straight to DONE with no iteration.
  - Divisor 0: the quotient is all-ones and the remainder is a.
  - Signed overflow, a = 100…0 and b = all-ones for div/rem: the quotient is a and the remainder is 0.
- Div accepted, normal case: restoring division on magnitudes, one quotient bit per cycle for DATA_WIDTH cycles. DONE then applies the signs: the quotient sign is sign(a)^sign(b), and the remainder takes the sign of a.
- Output registers hold unchanged while out_valid && !out_ready.
- flush has priority over every other event, including an acceptance in the same cycle. A flushed request produces no result.

## Timing
- Base op accepted at cycle t gives out_valid at t+1. Back-to-back issue at 1 op/cycle is possible when out_ready=1.
- Normal mul/div accepted at t gives out_valid at t+DATA_WIDTH+1 (DATA_WIDTH iteration cycles plus DONE). in_ready stays 0 from t+1 until out_valid is both set and consumed.
- Div special case accepted at t gives out_valid at t+2.
- If rst_n is deasserted mid-iteration, the outputs reach their reset values immediately (asynchronously). The first request is accepted on the first clock edge after release.

## Structure
- Package alu_pkg holds:
  - ALU_* localparams for the alu_ctr encodings.
  - MD_* localparams for the md_funct3 encodings.
  - The FSM state enum.
  - The DATA_WIDTH default.
- Sub-module md_iter holds the iterative mul/div datapath: accumulator, counter, and sign fixup, with start/done pins. The top level holds the base-op logic, the handshake and the output registers.

## Test plan
- Base ops: add with a=7, b=-3 → result 4; sra with a=0x80000000, b=4 → 0xF8000000; slt with a=-1, b=1 → result 1, less 1; sltu with the same operands → 0. out_valid appears one cycle after acceptance.
- Multiply: mulh 0x80000000×0x80000000 → 0x40000000; mul 0xFFFFFFFF×2 → 0xFFFFFFFE; mulhsu -1×0xFFFFFFFF → 0xFFFFFFFF. out_valid appears exactly 33 cycles after acceptance.
- Divide: div -7/2 → -3; rem -7/2 → -1; divu 0xFFFFFFFF/3 → 0x55555555. in_ready is low throughout.
- Divide special cases: div 5/0 → 0xFFFFFFFF; remu 5/0 → 5; div 0x80000000/-1 → 0x80000000; rem of the same operands → 0. All return out_valid at t+2.
- Backpressure: hold out_ready=0 for 5 cycles after a result. result stays stable, in_ready=0, and no new request is accepted; after out_ready rises, the next request is accepted in that same cycle.
- Abort: assert flush at iteration 10 of a div, and separately pulse rst_n low mid-mul. Each gives out_valid=0 and in_ready=1 on the next cycle, and a following add still returns the correct value.
